// File: rtl/latency_mem.sv
// latency_mem: single-port 32-bit data memory with a fixed, programmable
// access latency and a req/ack handshake. Out-of-range accesses complete
// normally but raise err and return zero.
module latency_mem #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteen,
    output logic [31:0] readdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  accept;
    logic                  complete;

    logic                  cap_we;
    logic [31:0]           cap_adr;
    logic [31:0]           cap_data;
    logic [3:0]            cap_be;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  in_range;

    logic [31:0]           mem [DEPTH];

    assign word_idx = cap_adr[DEPTH_LOG2+1:2];
    assign in_range = (cap_adr >> (DEPTH_LOG2 + 2)) == '0;
    assign busy     = (state == S_WAIT);

    // Next-state logic: accept in IDLE, count down in WAIT, complete at zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(LATENCY - 1);
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and latency counter register.
    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request fields when a request is accepted.
    always_ff @(posedge ph1) begin
        if (reset) begin
            cap_we   <= 1'b0;
            cap_adr  <= '0;
            cap_data <= '0;
            cap_be   <= '0;
        end else if (accept) begin
            cap_we   <= we;
            cap_adr  <= adr;
            cap_data <= writedata;
            cap_be   <= byteen;
        end
    end

    // Completion outputs: one-cycle ack/err pulses and registered read data.
    always_ff @(posedge ph1) begin
        if (reset) begin
            readdata <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack <= complete;
            err <= complete && !in_range;
            if (complete) begin
                if (!in_range) begin
                    readdata <= '0;
                end else if (!cap_we) begin
                    readdata <= mem[word_idx];
                end
            end
        end
    end

    // Byte-masked memory write; reset suppresses a write completing on the same edge.
    always_ff @(posedge ph1) begin
        if (!reset && complete && in_range && cap_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[word_idx][8*i +: 8] <= cap_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_latency_mem.sv
// tb_latency_mem: drives three latency_mem instances (LATENCY 1, 3, 15)
// with directed and randomized accesses and checks them against a
// word-array reference model of the memory and handshake timing.
module tb_latency_mem;

    logic            ph1 = 1'b0;
    logic            reset;
    logic [2:0]      req_v;
    logic [2:0]      we_v;
    logic [2:0][31:0] adr_v;
    logic [2:0][31:0] wd_v;
    logic [2:0][3:0] be_v;
    logic [2:0][31:0] rd_v;
    logic [2:0]      ack_v;
    logic [2:0]      busy_v;
    logic [2:0]      err_v;

    int tests = 0;
    int fails = 0;
    int lats [3] = '{1, 3, 15};

    logic [31:0] ref_mem [3][1024];
    bit          known   [3][1024];
    logic [31:0] last_rd [3];

    always #5 ph1 = ~ph1;

    latency_mem #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
        .ph1(ph1), .reset(reset), .req(req_v[0]), .we(we_v[0]), .adr(adr_v[0]),
        .writedata(wd_v[0]), .byteen(be_v[0]), .readdata(rd_v[0]),
        .ack(ack_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    latency_mem #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
        .ph1(ph1), .reset(reset), .req(req_v[1]), .we(we_v[1]), .adr(adr_v[1]),
        .writedata(wd_v[1]), .byteen(be_v[1]), .readdata(rd_v[1]),
        .ack(ack_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

    latency_mem #(.DEPTH_LOG2(10), .LATENCY(15)) u_l15 (
        .ph1(ph1), .reset(reset), .req(req_v[2]), .we(we_v[2]), .adr(adr_v[2]),
        .writedata(wd_v[2]), .byteen(be_v[2]), .readdata(rd_v[2]),
        .ack(ack_v[2]), .busy(busy_v[2]), .err(err_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access on instance k, starting and ending #1 after a posedge.
    task automatic access(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        int    lat;
        int    edges;
        int    idx;
        bit    oor;
        string pre;
        lat = lats[k];
        pre = $sformatf("L%0d %s@%h ", lat, w ? "wr" : "rd", a);
        oor = (a >> 12) != 32'd0;
        idx = int'(a[11:2]);
        we_v[k]  = w;
        adr_v[k] = a;
        wd_v[k]  = d;
        be_v[k]  = be;
        req_v[k] = 1'b1;
        @(posedge ph1); #1;
        req_v[k] = 1'b0;
        check({pre, "busy_accept"}, 32'(busy_v[k]), 32'd1);
        check({pre, "ack_early"}, 32'(ack_v[k]), 32'd0);
        edges = 0;
        do begin
            @(posedge ph1); #1;
            edges++;
            if (!ack_v[k]) check({pre, "busy_wait"}, 32'(busy_v[k]), 32'd1);
        end while (!ack_v[k] && edges < 40);
        check({pre, "ack_latency"}, 32'(edges), 32'(lat));
        check({pre, "busy_in_ack"}, 32'(busy_v[k]), 32'd0);
        check({pre, "err"}, 32'(err_v[k]), 32'(oor));
        if (oor) begin
            last_rd[k] = 32'd0;
        end else if (w) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[k][idx][8*i +: 8] = d[8*i +: 8];
            if (be == 4'hF) known[k][idx] = 1'b1;
        end else begin
            last_rd[k] = ref_mem[k][idx];
        end
        check({pre, "readdata"}, rd_v[k], last_rd[k]);
    endtask

    function automatic logic [31:0] pool_adr(input int j);
        return 32'((32'h100 + j) * 4) | 32'($urandom_range(0, 3));
    endfunction

    // Eight reads with req held high; each request is accepted the edge after the previous ack.
    task automatic b2b(input int k);
        int   lat;
        int   per;
        int   j;
        logic exp_ack;
        lat = lats[k];
        per = lat + 1;
        j   = 0;
        we_v[k]  = 1'b0;
        be_v[k]  = 4'hF;
        adr_v[k] = pool_adr(0);
        req_v[k] = 1'b1;
        @(posedge ph1); #1;
        for (int c = 1; c <= 8 * per - 1; c++) begin
            @(posedge ph1); #1;
            exp_ack = (c % per) == lat;
            check($sformatf("L%0d b2b ack c%0d", lat, c), 32'(ack_v[k]), 32'(exp_ack));
            check($sformatf("L%0d b2b busy c%0d", lat, c), 32'(busy_v[k]), 32'(!exp_ack));
            if (exp_ack) begin
                last_rd[k] = ref_mem[k][32'h100 + j];
                check($sformatf("L%0d b2b rd%0d", lat, j), rd_v[k], last_rd[k]);
                j++;
                if (j < 8) adr_v[k] = pool_adr(j);
                else       req_v[k] = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        req_v = '0; we_v = '0; adr_v = '0; wd_v = '0; be_v = '0;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge ph1);
        #1 reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            @(posedge ph1); #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("L%0d idle ack", lats[k]), 32'(ack_v[k]), 32'd0);
                check($sformatf("L%0d idle err", lats[k]), 32'(err_v[k]), 32'd0);
                check($sformatf("L%0d idle busy", lats[k]), 32'(busy_v[k]), 32'd0);
                check($sformatf("L%0d idle rd", lats[k]), rd_v[k], 32'd0);
            end
        end

        // Directed sequence on LATENCY=3
        access(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        access(1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("dir rd 0x10", rd_v[1], 32'hDEADBEEF);
        access(1, 1'b1, 32'h20, 32'h11223344, 4'hF);
        access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        access(1, 1'b0, 32'h20, 32'h0, 4'h0);
        check("dir partial 0x20", rd_v[1], 32'h11BB33DD);
        access(1, 1'b1, 32'h10, 32'h12345678, 4'h0);
        access(1, 1'b0, 32'h13, 32'h0, 4'h0);
        check("dir noop write 0x10", rd_v[1], 32'hDEADBEEF);
        access(1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
        access(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        access(1, 1'b0, 32'h1000, 32'h0, 4'h0);
        check("dir oor rd", rd_v[1], 32'h0);
        access(1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("dir rd 0x0", rd_v[1], 32'hCAFEF00D);
        access(1, 1'b1, 32'h40, 32'h01234567, 4'hF);

        // Randomized traffic on every latency, then back-to-back reads
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) access(k, 1'b1, pool_adr(j), $urandom, 4'hF);
            for (int n = 0; n < 24; n++) begin
                r = int'($urandom_range(0, 7));
                d = $urandom;
                if (r == 0) begin
                    a = (32'h1000 << $urandom_range(0, 19)) | ($urandom & 32'hFFF);
                end else begin
                    a = pool_adr(int'($urandom_range(0, 7)));
                end
                access(k, 1'($urandom), a, d, 4'($urandom));
            end
            b2b(k);
        end

        // Reset one edge after a write is accepted discards it
        we_v[1]  = 1'b1;
        adr_v[1] = 32'h40;
        wd_v[1]  = 32'h55AA55AA;
        be_v[1]  = 4'hF;
        req_v[1] = 1'b1;
        @(posedge ph1); #1;
        req_v[1] = 1'b0;
        reset    = 1'b1;
        @(posedge ph1); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'd0;
        check("rst busy", 32'(busy_v[1]), 32'd0);
        check("rst rd", rd_v[1], 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(posedge ph1); #1;
            check("rst no ack", 32'(ack_v[1]), 32'd0);
        end
        access(1, 1'b0, 32'h40, 32'h0, 4'h0);
        check("rst rd 0x40", rd_v[1], 32'h01234567);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
